// File: rtl/tfmt_pkg.sv
// rtl/tfmt_pkg.sv - T-format request map, frame layout offsets and poll FSM states
package tfmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TXWAIT,
    ST_RECV,
    ST_CHECK
  } state_t;

  localparam int MAX_FRAME = 11;

  localparam logic [7:0] CF_ID0 = 8'h02;
  localparam logic [7:0] CF_ID1 = 8'h8A;
  localparam logic [7:0] CF_ID2 = 8'h92;
  localparam logic [7:0] CF_ID3 = 8'h1A;

  localparam logic [3:0] LEN_SHORT = 4'd4;
  localparam logic [3:0] LEN_MID   = 4'd6;
  localparam logic [3:0] LEN_LONG  = 4'd11;

  // Byte offsets within a frame; byte 0 is always CF, the last byte is CRC.
  localparam int OFS_SF         = 1;
  localparam int OFS_ABS0       = 2;
  localparam int OFS_ABS1       = 3;
  localparam int OFS_ABS2       = 4;
  localparam int OFS_ENID_SHORT = 2;
  localparam int OFS_ENID_LONG  = 5;
  localparam int OFS_ABM0       = 6;
  localparam int OFS_ABM1       = 7;
  localparam int OFS_ABM2       = 8;
  localparam int OFS_ALMC       = 9;

  function automatic logic [7:0] cf_of(input logic [1:0] id);
    case (id)
      2'd0:    cf_of = CF_ID0;
      2'd1:    cf_of = CF_ID1;
      2'd2:    cf_of = CF_ID2;
      default: cf_of = CF_ID3;
    endcase
  endfunction

  function automatic logic [3:0] len_of(input logic [1:0] id);
    case (id)
      2'd0, 2'd1: len_of = LEN_MID;
      2'd2:       len_of = LEN_SHORT;
      default:    len_of = LEN_LONG;
    endcase
  endfunction

endpackage

// File: rtl/tfmt_frame_rx.sv
// rtl/tfmt_frame_rx.sv - reply collector: byte index, frame buffer, running XOR and idle timer
module tfmt_frame_rx
  import tfmt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        reload,
  input  logic                        run,
  input  logic                        accept,
  input  logic [3:0]                  frame_len,
  input  logic [7:0]                  cf,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_done,
  output logic [MAX_FRAME-2:1][7:0]   body,
  output logic                        frame_done,
  output logic                        expired,
  output logic                        crc_ok,
  output logic                        cf_ok
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [MAX_FRAME-2:0][7:0] bytes_q;
  logic [3:0]                idx;
  logic [7:0]                run_xor;
  logic [7:0]                last_byte;
  logic [TW-1:0]             timer;
  logic                      take;

  assign take       = accept && rx_done;
  assign frame_done = take && (idx == frame_len - 4'd1);
  // A byte arriving on the expiry cycle still counts as on time.
  assign expired    = run && !take && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign crc_ok     = (last_byte == run_xor);
  assign cf_ok      = (bytes_q[0] == cf);
  assign body       = bytes_q[MAX_FRAME-2:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q   <= '0;
      idx       <= '0;
      run_xor   <= '0;
      last_byte <= '0;
      timer     <= '0;
    end else if (clear) begin
      idx     <= '0;
      run_xor <= '0;
      timer   <= '0;
    end else if (take) begin
      if (frame_done) begin
        last_byte <= rx_data;
      end else begin
        bytes_q[idx] <= rx_data;
        run_xor      <= run_xor ^ rx_data;
      end
      idx   <= idx + 4'd1;
      timer <= '0;
    end else if (reload) begin
      timer <= '0;
    end else if (run && timer != TW'(TIMEOUT_CYCLES - 1)) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/tfmt_poll_engine.sv
// rtl/tfmt_poll_engine.sv - T-format encoder polling engine: request, collect, check, retry, publish
module tfmt_poll_engine
  import tfmt_pkg::*;
#(
  parameter int POLL_CYCLES    = 5000,
  parameter int TIMEOUT_CYCLES = 3000,
  parameter int MAX_RETRY      = 2,
  parameter int ANGLE_W        = 24,
  parameter int ERRCNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                auto_en,
  input  logic [1:0]          cmd_id,
  output logic [7:0]          tx_data,
  output logic                tx_en,
  input  logic                tx_busy,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic [ANGLE_W-1:0]  angle_out,
  output logic [23:0]         turn_out,
  output logic [7:0]          enid_out,
  output logic [7:0]          almc_out,
  output logic [7:0]          sf_out,
  output logic                data_valid,
  output logic                crc_err,
  output logic                timeout_err,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int PW = $clog2(POLL_CYCLES + 1);

  state_t                   state, state_nx;
  logic [PW-1:0]            poll_cnt;
  logic                     tick, trigger;
  logic [1:0]               cmd_lat;
  logic [7:0]               cf_lat;
  logic [3:0]               len_lat;
  logic [2:0]               retry;
  logic                     seen_busy;
  logic                     tx_done, good, bad, fail, give_up;
  logic                     frame_done, expired, crc_ok, cf_ok;
  logic [MAX_FRAME-2:1][7:0] body;
  logic [23:0]              abs_full;

  assign tick     = auto_en && (poll_cnt == PW'(POLL_CYCLES - 1));
  assign trigger  = (state == ST_IDLE) && (start || tick);
  assign cf_lat   = cf_of(cmd_lat);
  assign len_lat  = len_of(cmd_lat);
  assign abs_full = {body[OFS_ABS2], body[OFS_ABS1], body[OFS_ABS0]};

  assign tx_en   = (state == ST_SEND);
  assign tx_data = (state == ST_SEND) ? cf_lat : 8'h00;
  assign busy    = (state != ST_IDLE);

  tfmt_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == ST_SEND),
    .reload    (tx_done),
    .run       ((state == ST_TXWAIT) || (state == ST_RECV)),
    .accept    (state == ST_RECV),
    .frame_len (len_lat),
    .cf        (cf_lat),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .body      (body),
    .frame_done(frame_done),
    .expired   (expired),
    .crc_ok    (crc_ok),
    .cf_ok     (cf_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_done  = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    fail     = 1'b0;
    case (state)
      ST_IDLE:   if (trigger) state_nx = ST_SEND;
      ST_SEND:   state_nx = ST_TXWAIT;
      ST_TXWAIT: begin
        if (expired) begin
          fail = 1'b1;
        end else if (seen_busy && !tx_busy) begin
          tx_done  = 1'b1;
          state_nx = ST_RECV;
        end
      end
      ST_RECV: begin
        if (frame_done)   state_nx = ST_CHECK;
        else if (expired) fail = 1'b1;
      end
      ST_CHECK: begin
        if (cf_ok && crc_ok) begin
          good     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          bad  = 1'b1;
          fail = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    give_up = fail && (retry >= 3'(MAX_RETRY));
    if (fail) state_nx = give_up ? ST_IDLE : ST_SEND;
  end

  // Free-running poll counter; a tick landing while busy is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  poll_cnt <= '0;
    else if (!auto_en || tick)   poll_cnt <= '0;
    else                         poll_cnt <= poll_cnt + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_lat   <= '0;
      retry     <= '0;
      seen_busy <= 1'b0;
    end else begin
      if (trigger) begin
        cmd_lat <= cmd_id;
        retry   <= '0;
      end else if (fail) begin
        retry <= give_up ? 3'd0 : retry + 3'd1;
      end else if (good) begin
        retry <= '0;
      end
      if (state == ST_SEND)                    seen_busy <= 1'b0;
      else if (state == ST_TXWAIT && tx_busy)  seen_busy <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_out   <= '0;
      turn_out    <= '0;
      enid_out    <= '0;
      almc_out    <= '0;
      sf_out      <= '0;
      data_valid  <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      data_valid  <= good;
      crc_err     <= bad;
      timeout_err <= give_up;
      if (give_up && err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
      if (good) begin
        sf_out <= body[OFS_SF];
        if (len_lat == LEN_SHORT) begin
          enid_out <= body[OFS_ENID_SHORT];
        end else begin
          angle_out <= abs_full[ANGLE_W-1:0];
          if (len_lat == LEN_LONG) begin
            enid_out <= body[OFS_ENID_LONG];
            turn_out <= {body[OFS_ABM2], body[OFS_ABM1], body[OFS_ABM0]};
            almc_out <= body[OFS_ALMC];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tfmt_poll_engine.sv
// tb/tb_tfmt_poll_engine.sv - directed bench with a scripted encoder and a frame-level reference model
module tb_tfmt_poll_engine;

  localparam int POLL = 5000;
  localparam int TMO  = 3000;
  localparam int MR   = 2;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, auto_en = 1'b0;
  logic [1:0]  cmd_id = 2'd0;
  logic        tx_busy = 1'b0, rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  tx_data, enid_out, almc_out, sf_out;
  logic        tx_en, data_valid, crc_err, timeout_err, busy;
  logic [23:0] angle_out, turn_out;
  logic [15:0] err_cnt;

  tfmt_poll_engine #(
    .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR), .ANGLE_W(24), .ERRCNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en), .cmd_id(cmd_id),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy), .rx_data(rx_data), .rx_done(rx_done),
    .angle_out(angle_out), .turn_out(turn_out), .enid_out(enid_out), .almc_out(almc_out),
    .sf_out(sf_out), .data_valid(data_valid), .crc_err(crc_err), .timeout_err(timeout_err),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int len; logic [7:0] b [11]; } frame_t;

  int total = 0, bad = 0;
  frame_t fq[$];
  frame_t pend, rf;
  bit pend_valid = 0, rhave, ec_en = 1, abort = 0, resp_act = 0;
  int m_cmd = 0, att = 0, dv_due = -1, crc_due = -1, to_due = -1;
  int bytes_sent = 0, last_rx_cyc = -1, dv_cyc = -1;
  int tx_cnt = 0, crc_cnt = 0, to_cnt = 0;
  int tx_cyc[$];
  logic [23:0] m_angle = 0, m_turn = 0;
  logic [7:0]  m_enid = 0, m_almc = 0, m_sf = 0;
  logic [15:0] m_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] cf_tab(input int id);
    case (id)
      0: return 8'h02;
      1: return 8'h8A;
      2: return 8'h92;
      default: return 8'h1A;
    endcase
  endfunction

  function automatic frame_t mkf(input int len, input logic [0:10][7:0] v);
    frame_t f;
    f.len = len;
    for (int i = 0; i < 11; i++) f.b[i] = v[i];
    return f;
  endfunction

  // Spec-level view of a good reply: which fields the frame length carries.
  task automatic apply_frame(input frame_t f);
    m_sf = f.b[1];
    if (f.len == 4) m_enid = f.b[2];
    else begin
      m_angle = {f.b[4], f.b[3], f.b[2]};
      if (f.len == 11) begin
        m_enid = f.b[5];
        m_turn = {f.b[8], f.b[7], f.b[6]};
        m_almc = f.b[9];
      end
    end
  endtask

  task automatic judge(input frame_t f);
    logic [7:0] x = 8'h00;
    bit ok;
    if (abort) begin
      abort = 0;
      return;
    end
    for (int i = 0; i < f.len - 1; i++) x ^= f.b[i];
    ok = (f.b[0] == cf_tab(m_cmd)) && (f.b[f.len-1] == x);
    if (ok) begin
      pend = f; pend_valid = 1; dv_due = cyc + 2; att = 0;
    end else begin
      crc_due = cyc + 2;
      if (att > MR) begin
        to_due = cyc + 2; att = 0;
      end
    end
  endtask

  // Scripted encoder: answers every request with the next queued frame, or stays silent.
  initial begin
    forever begin
      tick();
      if (tx_en && rst_n) begin
        resp_act = 1;
        att++;
        rhave = fq.size() > 0;
        if (rhave) rf = fq.pop_front();
        repeat (2) tick();
        tx_busy = 1;
        repeat (8) tick();
        tx_busy = 0;
        if (rhave) begin
          for (int i = 0; i < rf.len; i++) begin
            repeat (3) tick();
            rx_data = rf.b[i];
            rx_done = 1;
            bytes_sent = i + 1;
            if (i == rf.len - 1) begin
              last_rx_cyc = cyc;
              judge(rf);
            end
            tick();
            rx_done = 0;
          end
        end
        resp_act = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc == dv_due && pend_valid) begin
      apply_frame(pend);
      pend_valid = 0;
    end
    if (cyc == to_due && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    if (tx_en) begin
      tx_cnt++;
      tx_cyc.push_back(cyc);
      chk("tx_data", {24'h0, tx_data}, {24'h0, cf_tab(m_cmd)});
    end
    if (data_valid) dv_cyc = cyc;
    if (crc_err) crc_cnt++;
    if (timeout_err) to_cnt++;
    chk("data_valid", {31'h0, data_valid}, {31'h0, cyc == dv_due});
    chk("crc_err", {31'h0, crc_err}, {31'h0, cyc == crc_due});
    chk("angle", {8'h0, angle_out}, {8'h0, m_angle});
    chk("turn", {8'h0, turn_out}, {8'h0, m_turn});
    chk("enid", {24'h0, enid_out}, {24'h0, m_enid});
    chk("almc", {24'h0, almc_out}, {24'h0, m_almc});
    chk("sf", {24'h0, sf_out}, {24'h0, m_sf});
    if (ec_en) begin
      chk("err_cnt", {16'h0, err_cnt}, {16'h0, m_err});
      chk("timeout_err", {31'h0, timeout_err}, {31'h0, cyc == to_due});
    end
  end

  task automatic request(input int id);
    cmd_id = 2'(id);
    m_cmd = id;
    dv_cyc = -1;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_dv(input string nm, input int lim);
    int n = 0;
    while (dv_cyc < 0 && n < lim) begin
      tick();
      n++;
    end
    chk(nm, {31'h0, dv_cyc >= 0}, 32'd1);
  endtask

  task automatic wait_quiet(input string nm, input int lim);
    int n = 0;
    tick();
    while ((resp_act || busy) && n < lim) begin
      tick();
      n++;
    end
    chk(nm, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int t0, c0;
    repeat (3) tick();
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_tx_en", {31'h0, tx_en}, 32'd0);
    chk("rst_angle", {8'h0, angle_out}, 32'd0);
    rst_n = 1;
    repeat (3) tick();

    // ID0 good frame
    t0 = tx_cnt;
    fq.push_back(mkf(6, {8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'h24, 40'h0}));
    request(0);
    wait_dv("id0_dv", 400);
    chk("id0_latency", dv_cyc - last_rx_cyc, 32'd2);
    chk("id0_angle", {8'h0, angle_out}, 32'h001234);
    chk("id0_sf", {24'h0, sf_out}, 32'h0);
    wait_quiet("id0_idle", 100);
    chk("id0_txcnt", tx_cnt - t0, 32'd1);

    // ID3 good frame
    fq.push_back(mkf(11, {8'h1A, 8'h00, 8'h56, 8'h34, 8'h12, 8'h17, 8'h05, 8'h00, 8'h00, 8'h00, 8'h78}));
    request(3);
    wait_dv("id3_dv", 500);
    chk("id3_angle", {8'h0, angle_out}, 32'h123456);
    chk("id3_turn", {8'h0, turn_out}, 32'h000005);
    chk("id3_enid", {24'h0, enid_out}, 32'h17);
    chk("id3_almc", {24'h0, almc_out}, 32'h00);
    wait_quiet("id3_idle", 100);

    // ID2 short frame touches only SF and ENID
    fq.push_back(mkf(4, {8'h92, 8'h05, 8'h2C, 8'hBB, 56'h0}));
    request(2);
    wait_dv("id2_dv", 400);
    chk("id2_enid", {24'h0, enid_out}, 32'h2C);
    chk("id2_angle_held", {8'h0, angle_out}, 32'h123456);
    wait_quiet("id2_idle", 100);

    // CRC error then retry
    t0 = tx_cnt; c0 = crc_cnt;
    fq.push_back(mkf(6, {8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'h25, 40'h0}));
    fq.push_back(mkf(6, {8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'h24, 40'h0}));
    request(0);
    wait_dv("retry_dv", 800);
    wait_quiet("retry_idle", 100);
    chk("retry_crc_cnt", crc_cnt - c0, 32'd1);
    chk("retry_txcnt", tx_cnt - t0, 32'd2);
    chk("retry_err_cnt", {16'h0, err_cnt}, 32'd0);

    // Silent encoder: retries exhausted by timeouts
    ec_en = 0;
    t0 = tx_cnt; c0 = to_cnt;
    request(0);
    begin
      int n = 0;
      while (to_cnt == c0 && n < 4 * (TMO + 200)) begin
        tick();
        n++;
      end
    end
    repeat (5) tick();
    chk("silent_to_cnt", to_cnt - c0, 32'd1);
    chk("silent_txcnt", tx_cnt - t0, 32'd3);
    chk("silent_gap_lo", {31'h0, (tx_cyc[t0+1] - tx_cyc[t0]) >= TMO}, 32'd1);
    chk("silent_gap_hi", {31'h0, (tx_cyc[t0+2] - tx_cyc[t0+1]) <= TMO + 40}, 32'd1);
    chk("silent_err_cnt", {16'h0, err_cnt}, 32'd1);
    chk("silent_angle_held", {8'h0, angle_out}, 32'h001234);
    m_err = 16'd1;
    att = 0;
    ec_en = 1;

    // Auto poll with busy-time starts and a cmd_id change mid-transaction
    t0 = tx_cnt;
    fq.push_back(mkf(6, {8'h8A, 8'h00, 8'hEF, 8'hBE, 8'h0A, 8'hD1, 40'h0}));
    fq.push_back(mkf(6, {8'h8A, 8'h00, 8'hEF, 8'hBE, 8'h0A, 8'hD1, 40'h0}));
    fq.push_back(mkf(6, {8'h8A, 8'h01, 8'h11, 8'h22, 8'h33, 8'h8B, 40'h0}));
    cmd_id = 2'd1; m_cmd = 1;
    auto_en = 1;
    for (int k = 1; k <= 3; k++) begin
      int n = 0;
      while (tx_cnt < t0 + k && n < POLL + 200) begin
        tick();
        n++;
      end
      repeat (20) tick();
      cmd_id = 2'd2;
      repeat (3) begin
        start = 1; tick(); start = 0; tick();
      end
      n = 0;
      while (resp_act && n < 200) begin
        tick();
        n++;
      end
      repeat (3) tick();
      cmd_id = 2'd1;
    end
    auto_en = 0;
    wait_quiet("auto_idle", 200);
    repeat (50) tick();
    chk("auto_txcnt", tx_cnt - t0, 32'd3);
    chk("auto_gap1", tx_cyc[t0+1] - tx_cyc[t0], POLL);
    chk("auto_gap2", tx_cyc[t0+2] - tx_cyc[t0+1], POLL);
    chk("auto_angle", {8'h0, angle_out}, 32'h332211);
    chk("auto_sf", {24'h0, sf_out}, 32'h01);

    // Reset in the middle of a reply
    bytes_sent = 0;
    fq.push_back(mkf(6, {8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'h24, 40'h0}));
    request(0);
    begin
      int n = 0;
      while (!(bytes_sent == 3 && rx_done == 0) && n < 200) begin
        tick();
        n++;
      end
    end
    chk("rst_mid_reached", bytes_sent, 32'd3);
    rst_n = 0;
    abort = 1;
    m_angle = 0; m_turn = 0; m_enid = 0; m_almc = 0; m_sf = 0; m_err = 0; att = 0;
    #1;
    chk("rst_mid_busy", {31'h0, busy}, 32'd0);
    chk("rst_mid_err_cnt", {16'h0, err_cnt}, 32'd0);
    chk("rst_mid_sf", {24'h0, sf_out}, 32'd0);
    chk("rst_mid_angle", {8'h0, angle_out}, 32'd0);
    repeat (3) tick();
    rst_n = 1;
    dv_cyc = -1;
    wait_quiet("rst_mid_idle", 200);
    repeat (10) tick();
    chk("rst_mid_no_dv", {31'h0, dv_cyc < 0}, 32'd1);
    fq.push_back(mkf(11, {8'h1A, 8'h00, 8'h56, 8'h34, 8'h12, 8'h17, 8'h05, 8'h00, 8'h00, 8'h00, 8'h78}));
    request(3);
    wait_dv("post_rst_dv", 500);
    chk("post_rst_angle", {8'h0, angle_out}, 32'h123456);
    wait_quiet("post_rst_idle", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tfmt_poll_engine.md
Name: tfmt_poll_engine

Overview:
- Parametrised T-format encoder polling engine, successor to the single-shot encoder decode top.
- Issues a control-field request byte to the byte-level UART transmitter and collects the frame length implied by the selected DATA ID from the byte-level UART receiver.
- Checks CF echo and CRC (x^8+1, XOR of all preceding bytes), with retry and timeout handling.
- Publishes angle/turn/ENID/ALMC/SF with a valid strobe; supports manual trigger and free-running periodic polling.

Parameters:
- POLL_CYCLES, 5000, auto-poll period in clk cycles (50 us at 100 MHz).
- TIMEOUT_CYCLES, 3000, max idle cycles while waiting for TX completion or for the next RX byte.
- MAX_RETRY, 2, extra attempts after a failed transaction (0..7).
- ANGLE_W, 24, published angle width (1..24); angle_out = ABS[ANGLE_W-1:0].
- ERRCNT_W, 16, error counter width.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  manual trigger pulse
- auto_en  in  1  enable periodic polling
- cmd_id  in  2  request select: 0=ID0, 1=ID1, 2=ID2, 3=ID3
- tx_data  out  8  request byte to the UART transmitter
- tx_en  out  1  one-cycle send strobe
- tx_busy  in  1  transmitter active flag; also drives the RS485 RE
- rx_data  in  8  received byte
- rx_done  in  1  one-cycle byte-received strobe
- angle_out  out  ANGLE_W  absolute angle {ABS2,ABS1,ABS0}, truncated
- turn_out  out  24  multi-turn {ABM2,ABM1,ABM0}; ID3 only
- enid_out  out  8  encoder ID; ID2/ID3
- almc_out  out  8  alarm byte; ID3
- sf_out  out  8  status field
- data_valid  out  1  one-cycle pulse on a good frame
- crc_err  out  1  one-cycle pulse per CRC/CF mismatch attempt
- timeout_err  out  1  one-cycle pulse when retries are exhausted
- busy  out  1  high outside IDLE
- err_cnt  out  ERRCNT_W  saturating count of failed transactions (retries exhausted)

Behaviour:
- Reset: all outputs 0; state IDLE; poll counter 0.
- Request map (CF byte, frame bytes including CF and CRC):
  - ID0: 0x02, 6
  - ID1: 0x8A, 6
  - ID2: 0x92, 4
  - ID3: 0x1A, 11
- Frame field order:
  - 6-byte frames: CF, SF, ABS0, ABS1, ABS2, CRC
  - 4-byte frame: CF, SF, ENID, CRC
  - 11-byte frame: CF, SF, ABS0, ABS1, ABS2, ENID, ABM0, ABM1, ABM2, ALMC, CRC
- Trigger:
  - Trigger sources are a start pulse while in IDLE, or a poll tick.
  - Poll tick fires when auto_en=1 and the poll counter reaches POLL_CYCLES-1; the counter then wraps to 0.
  - The poll counter runs freely while auto_en=1 and clears while auto_en=0.
  - A tick or start that arrives while busy is dropped.
  - start and tick in the same cycle produce one transaction.
  - cmd_id is latched at the trigger; later changes do not affect the transaction in flight.
- FSM states: IDLE -> SEND -> TXWAIT -> RECV -> CHECK -> IDLE / SEND(retry).
  - SEND: tx_data=CF, tx_en=1 for one cycle; clear byte index, running XOR and timer.
  - TXWAIT: wait for a tx_busy rise then fall; the timer runs; expiry counts as a failed attempt.
  - RECV:
    - Each rx_done stores the byte at its index, XORs it into the running CRC except for the last byte, and reloads the timer.
    - Timer expiry counts as a failed attempt.
    - Receipt of the final byte goes to CHECK.
    - rx_done outside RECV is ignored.
  - CHECK (1 cycle):
    - Good frame: byte0==CF and last byte==running XOR.
    - Good: update only the fields present in the frame; pulse data_valid; retry counter cleared; go to IDLE.
    - Bad: pulse crc_err.
- Failed attempt (CRC/CF mismatch or timeout):
  - If retry < MAX_RETRY: retry+1, back to SEND next cycle.
  - Otherwise: pulse timeout_err (also on a final CRC failure), err_cnt+1 saturating at all-ones, go to IDLE.
- Output fields hold their last good values across errors.
- Latency: data_valid asserts exactly 2 cycles after the final rx_done (register + CHECK).
- Asynchronous reset mid-operation aborts immediately with no strobes; later stray rx_done strobes are ignored in IDLE.

Decomposition:
- Package tfmt_pkg:
  - CF constants and frame-length table per cmd_id.
  - FSM state enum.
  - Field byte offsets for 6/4/11-byte frames.
- Sub-module tfmt_frame_rx: byte index, frame buffer, running XOR and inter-byte timer; reports frame_done, crc_ok, cf_ok.

Test Plan:
- ID0 good frame: start, cmd_id=0 -> tx_data=0x02 once; reply 02 00 34 12 00 24 -> data_valid 2 cycles after last byte, angle_out=0x001234, sf_out=0x00, no errors.
- ID3 good frame: reply 1A 00 56 34 12 17 05 00 00 00 78 -> angle_out=0x123456, turn_out=0x000005, enid_out=0x17, almc_out=0x00.
- CRC retry: ID0 reply with CRC 0x25, then the correct frame -> one crc_err pulse, second tx_en with 0x02, then data_valid; err_cnt stays 0.
- Silent encoder, MAX_RETRY=2: 3 tx_en strobes, each followed by TIMEOUT_CYCLES -> one timeout_err, err_cnt=1, angle_out unchanged from the previous value.
- Auto poll: auto_en=1, immediate replies -> tx_en spaced exactly 5000 cycles; start pulses while busy produce no extra request.
- Reset mid-RECV (after 3 of 6 bytes): rst_n low -> all outputs 0, busy=0; remaining bytes produce no data_valid; next start works normally.
